// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding and field widths.
package mux_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int SEL_W  = 3;
  localparam int BCNT_W = 4;

endpackage

// File: rtl/rr_pick8.sv
// Combinational 8-way round-robin picker: the search starts one past the last
// winner. It rotates the requests, priority-encodes them, then un-rotates the result.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [7:0]       req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] start;
  logic [15:0]      dbl;
  logic [7:0]       rot;
  logic [SEL_W-1:0] pos;

  // 3-bit arithmetic makes last == 7 wrap the search start to 0.
  assign start = last + 3'd1;
  assign dbl   = {req, req} >> start;
  assign rot   = dbl[7:0];

  // Lowest set bit of the rotated vector is the nearest requester after last.
  always_comb begin
    pos = '0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) pos = SEL_W'(k);
    end
  end

  assign idx = start + pos;
  assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 8:1 mux between N requesters.
// A grant is held for up to MAX_BURST beats. Accepted words land in a
// single-entry output register with a valid/ready handshake.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [BCNT_W-1:0]  burst_q, burst_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_src_q, out_src_d;

  logic [SEL_W-1:0]   win_idx;
  logic               win_any;
  logic               can_take;
  logic               accept;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .idx  (win_idx),
    .any  (win_any)
  );

  // The output slot can take a beat when it is empty or being drained this cycle.
  // in_ready never depends on req, so no combinational loop can form through a producer.
  assign can_take  = !out_valid_q || out_ready;
  assign accept    = (state_q == ST_GRANT) && req[sel_q] && can_take;
  assign in_ready  = ((state_q == ST_GRANT) && can_take) ? grant_q : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == ST_GRANT);

  // Next-state logic for the grant FSM, the burst counter and the output slot.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_d      = last_q;
    burst_d     = burst_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d          = ST_GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          sel_d            = win_idx;
          burst_d          = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          burst_d = burst_q + 4'd1;
          if (burst_q == BCNT_W'(MAX_BURST - 1)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = sel_q;
          end
        end else if (!req[sel_q]) begin
          // The owner dropped its request; this also releases while backpressured.
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = sel_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new beat overwrites a draining one, which keeps throughput at 1 beat/cycle.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(sel_q)*WIDTH +: WIDTH];
      out_src_d   = sel_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; last_q resets to 7 so that requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      last_q      <= 3'd7;
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

endmodule
